dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the datapath's load/store port and main memory.
- Supplies the ReadData input of the writeback result mux.
- Stalls the core on read misses and on stores, refilling 4-word lines from memory over a valid-strobed read channel.

Parameters:
DATA_WIDTH, 32, word width of the CPU and memory data buses
INDEX_BITS, 5, number of line-index bits (2^5 = 32 lines)
WORDS_PER_LINE, 4, words per line; fixes the 2-bit word offset and the refill beat count

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-low reset
ADDR  input  32  byte address from ALUResult; [1:0] ignored, [3:2] word, [8:4] index, [31:9] tag
WRITE_DATA  input  32  store data
MEM_READ  input  1  load request, level, held while STALL=1
MEM_WRITE  input  1  store request, level, held while STALL=1
READ_DATA  output  32  load data toward the result mux
STALL  output  1  combinational; freezes the core while 1
MEM_ADDR  output  32  memory word address, registered
MEM_RD_REQ  output  1  line-refill request, registered, level
MEM_RD_DATA  input  32  refill word
MEM_RD_VALID  input  1  one refill word is valid this cycle
MEM_WR_REQ  output  1  write-through request, registered, level
MEM_WR_DATA  output  32  write-through data, registered
MEM_WR_ACK  input  1  memory accepted the write this cycle

Behaviour:
- Storage: 32 lines × 4 words data; 23-bit tag and 1 valid bit per line. hit = valid[index] & (tag[index] == ADDR[31:9]).
- Reset (RST=0 at an edge):
  - all valid bits cleared; state = IDLE; beat counter = 0;
  - MEM_RD_REQ=0, MEM_WR_REQ=0, MEM_ADDR=0, MEM_WR_DATA=0.
  - Reset mid-refill or mid-write aborts the operation; the line stays invalid.
- READ_DATA = data[index][word] when MEM_READ & hit & state=IDLE; otherwise 0.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - MEM_WRITE=1 (takes priority if MEM_READ is also 1): STALL=1. Next edge: go to WRITE, load MEM_ADDR={ADDR[31:2],2'b00} and MEM_WR_DATA=WRITE_DATA, set MEM_WR_REQ=1. On a hit, the cached word is updated at that same edge; on a miss, the cache is not modified.
  - MEM_READ=1 and hit: STALL=0; zero-latency hit.
  - MEM_READ=1 and miss: STALL=1. Next edge: go to REFILL, MEM_ADDR={ADDR[31:4],4'b0}, MEM_RD_REQ=1, counter=0.
  - Neither request: STALL=0, no action.
  - MEM_RD_VALID and MEM_WR_ACK are ignored in IDLE.
- REFILL (STALL=1 throughout):
  - Each edge with MEM_RD_VALID=1: write MEM_RD_DATA into data[index][counter], increment counter, increment MEM_ADDR by 4.
  - On the edge accepting beat 3: write tag, set valid, MEM_RD_REQ=0, counter wraps to 0, go to IDLE.
  - The following IDLE cycle hits and STALL drops, so a minimum read-miss penalty is 5 stall cycles plus memory latency.
  - Gaps between beats are allowed. MEM_WR_ACK is ignored.
- WRITE:
  - STALL = ~MEM_WR_ACK; the core advances on the ack cycle.
  - On the ack edge: MEM_WR_REQ=0, go to IDLE.
  - MEM_ADDR and MEM_WR_DATA stay stable until the ack. MEM_RD_VALID is ignored.
- Index/tag are sampled from ADDR continuously; the core guarantees ADDR is stable while STALL=1.

Test Plan:
- Reset, then load ADDR=0x0000_0104 → STALL=1 same cycle; next cycle MEM_RD_REQ=1, MEM_ADDR=0x100. Supply 0xA0,0xA1,0xA2,0xA3 on consecutive cycles → MEM_ADDR steps 0x100→0x10C; after beat 4, MEM_RD_REQ=0; next cycle STALL=0 and READ_DATA=0xA1.
- After refill, load 0x10C → STALL=0, READ_DATA=0xA3 in the same cycle, no memory request.
- Store 0xDEAD_BEEF to 0x108 (hit) → MEM_WR_REQ=1, MEM_ADDR=0x108. Hold ack low 3 cycles, then pulse MEM_WR_ACK → STALL low only in the ack cycle. Following load of 0x108 hits with 0xDEAD_BEEF.
- Store to 0x2000 (miss) then load 0x2000 → load misses and refills; cache was not allocated by the store.
- Load 0x0000_0304 (same index as 0x104, different tag) → miss and refill replaces the line; a later load of 0x104 misses again.
- Assert RST=0 after 2 refill beats → MEM_RD_REQ=0 next edge, state IDLE; reload of the same address misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Load hits return data combinationally; read misses refill a whole line and stores write through.
module dcache_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_BITS     = 5,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           ADDR,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  output logic [DATA_WIDTH-1:0] READ_DATA,
  output logic                  STALL,
  output logic [31:0]           MEM_ADDR,
  output logic                  MEM_RD_REQ,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  input  logic                  MEM_RD_VALID,
  output logic                  MEM_WR_REQ,
  output logic [DATA_WIDTH-1:0] MEM_WR_DATA,
  input  logic                  MEM_WR_ACK
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_LSB  = 2 + OFF_BITS + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam logic [31:0]         LINE_MASK = ~((32'd1 << (2 + OFF_BITS)) - 32'd1);
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q;

  state_e                state_q, state_d;
  logic [OFF_BITS-1:0]   cnt_q, cnt_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [INDEX_BITS-1:0] idx_s;
  logic [OFF_BITS-1:0]   word_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s;
  logic                  data_we_s;
  logic [OFF_BITS-1:0]   data_wword_s;
  logic [DATA_WIDTH-1:0] data_wdata_s;
  logic                  fill_s;

  assign idx_s  = ADDR[2+OFF_BITS +: INDEX_BITS];
  assign word_s = ADDR[2 +: OFF_BITS];
  assign tag_s  = ADDR[31:TAG_LSB];
  assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

  assign READ_DATA   = (MEM_READ && hit_s && (state_q == IDLE)) ? data_q[idx_s][word_s]
                                                                : {DATA_WIDTH{1'b0}};
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_RD_REQ  = rd_req_q;
  assign MEM_WR_REQ  = wr_req_q;
  assign MEM_WR_DATA = wr_data_q;

  // Next-state, stall and array-write decode for the three controller states.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    wr_data_d    = wr_data_q;
    STALL        = 1'b0;
    data_we_s    = 1'b0;
    data_wword_s = word_s;
    data_wdata_s = WRITE_DATA;
    fill_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_WRITE) begin
          // Stores win over loads; a miss leaves the cache untouched.
          STALL      = 1'b1;
          state_d    = WRITE;
          mem_addr_d = {ADDR[31:2], 2'b00};
          wr_data_d  = WRITE_DATA;
          wr_req_d   = 1'b1;
          data_we_s  = hit_s;
        end else if (MEM_READ && !hit_s) begin
          STALL      = 1'b1;
          state_d    = REFILL;
          mem_addr_d = ADDR & LINE_MASK;
          rd_req_d   = 1'b1;
          cnt_d      = {OFF_BITS{1'b0}};
        end else begin
          STALL = 1'b0;
        end
      end
      REFILL: begin
        STALL = 1'b1;
        if (MEM_RD_VALID) begin
          data_we_s    = 1'b1;
          data_wword_s = cnt_q;
          data_wdata_s = MEM_RD_DATA;
          cnt_d        = cnt_q + OFF_BITS'(1);
          mem_addr_d   = mem_addr_q + 32'd4;
          if (cnt_q == LAST_BEAT) begin
            fill_s   = 1'b1;
            rd_req_d = 1'b0;
            cnt_d    = {OFF_BITS{1'b0}};
            state_d  = IDLE;
          end else begin
            fill_s = 1'b0;
          end
        end else begin
          data_we_s = 1'b0;
        end
      end
      WRITE: begin
        STALL = ~MEM_WR_ACK;
        if (MEM_WR_ACK) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end else begin
          wr_req_d = 1'b1;
        end
      end
      default: begin
        STALL   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with synchronous active-low reset; reset aborts any refill or write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= {OFF_BITS{1'b0}};
      mem_addr_q <= 32'd0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= {DATA_WIDTH{1'b0}};
      valid_q    <= {LINES{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      if (fill_s) begin
        valid_q[idx_s] <= 1'b1;
      end
    end
  end

  // Data and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge CLK) begin
    if (RST && data_we_s) begin
      data_q[idx_s][data_wword_s] <= data_wdata_s;
    end
    if (RST && fill_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the reference treats the cache as transparent over a memory
// array and tracks which tag occupies each line to predict hit or miss.
module tb_dcache_ctrl;

  logic        CLK;
  logic        RST;
  logic [31:0] ADDR, WRITE_DATA, READ_DATA, MEM_ADDR, MEM_RD_DATA, MEM_WR_DATA;
  logic        MEM_READ, MEM_WRITE, STALL, MEM_RD_REQ, MEM_RD_VALID, MEM_WR_REQ, MEM_WR_ACK;

  dcache_ctrl dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .READ_DATA(READ_DATA), .STALL(STALL),
    .MEM_ADDR(MEM_ADDR), .MEM_RD_REQ(MEM_RD_REQ), .MEM_RD_DATA(MEM_RD_DATA),
    .MEM_RD_VALID(MEM_RD_VALID), .MEM_WR_REQ(MEM_WR_REQ), .MEM_WR_DATA(MEM_WR_DATA),
    .MEM_WR_ACK(MEM_WR_ACK)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    int          stall;   // exact stall cycles, or -1 for "at least 5"
  } exp_t;

  exp_t        exp_q [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mem [logic [29:0]];
  bit          lv [32];
  logic [22:0] lt [32];
  bit          gap_en = 1'b0;
  int          wr_lat = 0;
  int          beat_k = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memval(logic [29:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0] ^ 16'h5A5A, wa[15:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a request completes (request held with STALL low).
  initial begin
    int   sc;
    exp_t e;
    sc = 0;
    forever begin
      @(negedge CLK);
      #3;
      if (!RST) begin
        sc = 0;
      end else if (MEM_READ || MEM_WRITE) begin
        if (STALL) begin
          sc++;
        end else begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_completion: addr %h with empty scoreboard", ADDR);
          end else begin
            e = exp_q.pop_front();
            if (e.is_wr) begin
              check("st_mem_addr", MEM_ADDR, {e.addr[31:2], 2'b00});
              check("st_mem_data", MEM_WR_DATA, e.data);
              check("st_wr_req", {31'd0, MEM_WR_REQ}, 32'd1);
              check("st_stall_cycles", 32'(sc), 32'(e.stall));
            end else begin
              check("ld_data", READ_DATA, e.data);
              check("ld_no_rd_req", {31'd0, MEM_RD_REQ}, 32'd0);
              if (e.hit) check("ld_hit_stall", 32'(sc), 32'd0);
              else if (e.stall >= 0) check("ld_miss_stall", 32'(sc), 32'(e.stall));
              else check("ld_miss_stall_ge5", 32'(sc), (sc >= 5) ? 32'(sc) : 32'd5);
            end
          end
          sc = 0;
        end
      end else begin
        sc = 0;
      end
    end
  end

  // Memory model: refill beats (optionally gapped) from the model array, delayed write acks.
  initial begin
    int          ww;
    logic [31:0] base;
    ww = 0;
    MEM_RD_VALID = 1'b0;
    MEM_RD_DATA  = 32'd0;
    MEM_WR_ACK   = 1'b0;
    forever begin
      @(negedge CLK);
      if (!MEM_RD_REQ) begin
        beat_k       = 0;
        MEM_RD_VALID = 1'b0;
      end else begin
        if (MEM_RD_VALID) beat_k++;
        if (exp_q.size() > 0) begin
          base = exp_q[0].addr & 32'hFFFF_FFF0;
          check("refill_mem_addr", MEM_ADDR, base + 32'(4 * beat_k));
          MEM_RD_VALID = !(gap_en && ($urandom_range(0, 2) == 0));
          MEM_RD_DATA  = memval(30'((base >> 2) + 32'(beat_k)));
        end else begin
          MEM_RD_VALID = 1'b0;
        end
      end
      if (MEM_WR_ACK) begin
        MEM_WR_ACK = 1'b0;
        ww = 0;
      end else if (MEM_WR_REQ) begin
        if (ww >= wr_lat) MEM_WR_ACK = 1'b1;
        else ww++;
      end else begin
        ww = 0;
      end
    end
  end

  // Issue one request at a negedge, record its expected outcome, hold it until it completes.
  task automatic run_txn(bit is_wr, bit both, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    int          idx;
    logic [22:0] tg;
    bit          done;
    idx     = int'(a[8:4]);
    tg      = a[31:9];
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    e.hit   = lv[idx] && (lt[idx] == tg);
    e.stall = -1;
    if (is_wr) begin
      mem[a[31:2]] = d;
      e.stall      = 1 + wr_lat;
    end else begin
      e.data = memval(a[31:2]);
      if (!e.hit && !gap_en) e.stall = 5;
      lv[idx] = 1'b1;
      lt[idx] = tg;
    end
    exp_q.push_back(e);
    ADDR       = a;
    WRITE_DATA = is_wr ? d : $urandom;
    MEM_WRITE  = is_wr;
    MEM_READ   = !is_wr || both;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #3;
      if (!STALL) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout: addr %h still stalled, expected completion", a);
      exp_q.delete();
    end
    @(negedge CLK);
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  initial begin
    bit done;
    RST        = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    ADDR       = 32'd0;
    WRITE_DATA = 32'd0;
    for (int i = 0; i < 32; i++) begin
      lv[i] = 1'b0;
      lt[i] = 23'd0;
    end
    mem[30'h40] = 32'h0000_00A0;
    mem[30'h41] = 32'h0000_00A1;
    mem[30'h42] = 32'h0000_00A2;
    mem[30'h43] = 32'h0000_00A3;

    repeat (3) @(negedge CLK);
    #3;
    check("rst_stall", {31'd0, STALL}, 32'd0);
    check("rst_rd_req", {31'd0, MEM_RD_REQ}, 32'd0);
    check("rst_wr_req", {31'd0, MEM_WR_REQ}, 32'd0);
    check("rst_mem_addr", MEM_ADDR, 32'd0);
    check("rst_wr_data", MEM_WR_DATA, 32'd0);
    check("rst_read_data", READ_DATA, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Directed scenarios with back-to-back refill beats.
    gap_en = 1'b0;
    wr_lat = 0;
    run_txn(1'b0, 1'b0, 32'h0000_0104, 32'd0);
    run_txn(1'b0, 1'b0, 32'h0000_010C, 32'd0);
    wr_lat = 3;
    run_txn(1'b1, 1'b0, 32'h0000_0108, 32'hDEAD_BEEF);
    wr_lat = 0;
    run_txn(1'b0, 1'b0, 32'h0000_0108, 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678);
    run_txn(1'b0, 1'b0, 32'h0000_2000, 32'd0);
    run_txn(1'b0, 1'b0, 32'h0000_0304, 32'd0);
    run_txn(1'b0, 1'b0, 32'h0000_0104, 32'd0);
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_0001);
    run_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0);

    // Reset in the middle of a refill.
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h0000_0504, data: 32'd0, hit: 1'b0, stall: -1});
    ADDR     = 32'h0000_0504;
    MEM_READ = 1'b1;
    done     = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #3;
      if (beat_k >= 2) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL abort_beats: saw %0d refill beats, expected 2", beat_k);
    end
    @(negedge CLK);
    RST      = 1'b0;
    MEM_READ = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) lv[i] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #3;
    check("abort_rd_req", {31'd0, MEM_RD_REQ}, 32'd0);
    check("abort_stall", {31'd0, STALL}, 32'd0);
    check("abort_mem_addr", MEM_ADDR, 32'd0);
    @(negedge CLK);
    run_txn(1'b0, 1'b0, 32'h0000_0504, 32'd0);
    run_txn(1'b0, 1'b0, 32'h0000_0504, 32'd0);

    // Randomized traffic over a small address pool so hits, conflicts and store hits all occur.
    gap_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit          wr;
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      wr = ($urandom_range(0, 9) < 4);
      wr_lat = $urandom_range(0, 3);
      run_txn(wr, wr && ($urandom_range(0, 3) == 0), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
